// File: rtl/hash_pkg.sv
// Shared constants and types for the hash array and its hit collector.
// HIT_TIMESTAMP_EN adds a 32-bit cycle stamp to every hit record.
package hash_pkg;

  localparam int unsigned CSDIV2    = 16;  // last-char groups per seed
  localparam int unsigned SEED_LAT  = 5;   // seed change -> matching success
  localparam int unsigned PHASE_LAT = 4;   // phase value -> matching success
  localparam int unsigned PHASE_W   = $clog2(CSDIV2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } coll_state_e;

  typedef struct packed {
    logic [31:0]        seed;
    logic [PHASE_W-1:0] phase;
`ifdef HIT_TIMESTAMP_EN
    logic [31:0]        stamp;
`endif
  } hit_rec_t;

endpackage

// File: rtl/hit_fifo.sv
// Synchronous FIFO of hit records with a registered head. The caller never pushes
// when full unless it pops in the same cycle.
module hit_fifo
  import hash_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push_i,
  input  hit_rec_t push_rec_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     head_valid_o,
  output hit_rec_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  hit_rec_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            valid_q;
  hit_rec_t        head_q, head_d;
  logic            do_pop;

  assign do_pop       = pop_i & valid_q;
  assign full_o       = (cnt_q == (AW+1)'(DEPTH));
  assign head_valid_o = valid_q;
  assign head_o       = head_q;

  // Next read pointer, occupancy and head; bypass when the new head is written this cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    head_d = mem_q[rd_ptr_d];
    if (push_i && (wr_ptr_q == rd_ptr_d)) head_d = push_rec_i;
  end

  // Storage array; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_rec_i;
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= (cnt_d != '0);
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/hash_hit_collector.sv
// Collects candidate hits from the parallel hash array: mirrors its phase counter,
// aligns seed/phase with the pipelined success flag and queues {seed, phase} records.
// HIT_TIMESTAMP_EN adds hit_time and a per-record cycle stamp.
module hash_hit_collector
  import hash_pkg::*;
#(
  parameter int unsigned HIT_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               reset_counter,
  input  logic [31:0]        seed,
  input  logic               success,
  input  logic               next_initial,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [31:0]        hit_seed,
  output logic [PHASE_W-1:0] hit_phase,
  output logic [15:0]        hit_count,
  output logic               overflow,
  output logic               phase_err,
`ifdef HIT_TIMESTAMP_EN
  output logic [31:0]        hit_time,
`endif
  output logic               busy
);

  localparam int unsigned DW = $clog2(SEED_LAT + 1);

  coll_state_e        state_q;
  logic [DW-1:0]      drain_q;
  logic [PHASE_W-1:0] phase_q;
  logic [31:0]        seed_dly_q  [SEED_LAT];
  logic [PHASE_W-1:0] phase_dly_q [PHASE_LAT];
  logic [SEED_LAT-1:0] armed_q;
  logic [15:0]        count_q;
  logic               ovf_q, perr_q;

  logic     start_go, armed_tap, capture, pop, fifo_full, push_ok, drop, phase_last;
  hit_rec_t rec, head;

  assign start_go   = (state_q == IDLE) & start;
  assign armed_tap  = armed_q[SEED_LAT-1];
  assign capture    = success & armed_tap & (state_q != IDLE);
  assign pop        = hit_valid & hit_ready;
  assign push_ok    = capture & (~fifo_full | pop);
  assign drop       = capture & fifo_full & ~pop;
  assign phase_last = (phase_q == PHASE_W'(CSDIV2 - 1));

  // Collector FSM: DRAIN keeps capturing until the last armed slot has left the pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_q <= RUN;
        RUN: if (stop) begin
          state_q <= DRAIN;
          drain_q <= '0;
        end
        DRAIN: begin
          if (drain_q == DW'(SEED_LAT - 1)) state_q <= IDLE;
          else drain_q <= drain_q + DW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Mirror of the array's last-char phase counter; free-running in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           phase_q <= '0;
    else if (reset_counter) phase_q <= '0;
    else if (phase_last)    phase_q <= '0;
    else                    phase_q <= phase_q + PHASE_W'(1);
  end

  // Alignment delay lines; the armed line marks results that belong to this RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SEED_LAT; i++) seed_dly_q[i] <= '0;
      for (int i = 0; i < PHASE_LAT; i++) phase_dly_q[i] <= '0;
      armed_q <= '0;
    end else begin
      seed_dly_q[0] <= seed;
      for (int i = 1; i < SEED_LAT; i++) seed_dly_q[i] <= seed_dly_q[i-1];
      phase_dly_q[0] <= phase_q;
      for (int i = 1; i < PHASE_LAT; i++) phase_dly_q[i] <= phase_dly_q[i-1];
      if (reset_counter || start_go) armed_q <= '0;
      else armed_q <= {armed_q[SEED_LAT-2:0], (state_q == RUN)};
    end
  end

`ifdef HIT_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] stamp_dly_q [SEED_LAT];

  // Cycle stamp travels alongside the seed so it names the cycle the seed was presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q <= '0;
      for (int i = 0; i < SEED_LAT; i++) stamp_dly_q[i] <= '0;
    end else begin
      cycle_q <= start_go ? 32'd0 : cycle_q + 32'd1;
      stamp_dly_q[0] <= cycle_q;
      for (int i = 1; i < SEED_LAT; i++) stamp_dly_q[i] <= stamp_dly_q[i-1];
    end
  end
`endif

  // Record built from the aligned taps.
  always_comb begin
    rec       = '0;
    rec.seed  = seed_dly_q[SEED_LAT-1];
    rec.phase = phase_dly_q[PHASE_LAT-1];
`ifdef HIT_TIMESTAMP_EN
    rec.stamp = stamp_dly_q[SEED_LAT-1];
`endif
  end

  // Hit statistics and sticky error flags; start clears them for the new run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else if (start_go) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (push_ok && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
      if (drop) ovf_q <= 1'b1;
      if (armed_tap && (next_initial != phase_last)) perr_q <= 1'b1;
    end
  end

  hit_fifo #(
    .DEPTH (HIT_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push_ok),
    .push_rec_i   (rec),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .head_valid_o (hit_valid),
    .head_o       (head)
  );

  assign hit_seed  = head.seed;
  assign hit_phase = head.phase;
`ifdef HIT_TIMESTAMP_EN
  assign hit_time  = head.stamp;
`endif
  assign hit_count = count_q;
  assign overflow  = ovf_q;
  assign phase_err = perr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hash_hit_collector.sv
// Bench for hash_hit_collector: directed scenarios plus random traffic against a
// cycle-indexed behavioural model built from history tables.
module tb_hash_hit_collector;
  import hash_pkg::*;

  localparam int DEPTH = 8;
  localparam int SL    = SEED_LAT;
  localparam int PL    = PHASE_LAT;
  localparam int CS    = CSDIV2;
  localparam int H     = 64;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0, stop = 1'b0, reset_counter = 1'b0;
  logic [31:0]        seed = '0;
  logic               success = 1'b0, next_initial = 1'b0, hit_ready = 1'b0;
  logic               hit_valid, overflow, phase_err, busy;
  logic [31:0]        hit_seed;
  logic [PHASE_W-1:0] hit_phase;
  logic [15:0]        hit_count;
`ifdef HIT_TIMESTAMP_EN
  logic [31:0]        hit_time;
`endif

  always #5 clk = ~clk;

  hash_hit_collector #(
    .HIT_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .reset_counter (reset_counter),
    .seed          (seed),
    .success       (success),
    .next_initial  (next_initial),
    .hit_valid     (hit_valid),
    .hit_ready     (hit_ready),
    .hit_seed      (hit_seed),
    .hit_phase     (hit_phase),
    .hit_count     (hit_count),
    .overflow      (overflow),
    .phase_err     (phase_err),
`ifdef HIT_TIMESTAMP_EN
    .hit_time      (hit_time),
`endif
    .busy          (busy)
  );

  int tests = 0;
  int fails = 0;

  // Model: queue of expected records plus per-cycle history of what was presented.
  typedef struct {
    logic [31:0] s;
    int          p;
  } rec_t;
  rec_t q[$];
  int   m_state;  // 0 idle, 1 run, 2 drain
  int   m_left, m_count, cyc, anchor;
  bit   m_ovf, m_perr, ni_flip;
  logic [31:0] h_seed [H];
  int   h_phase [H];
  bit   h_run [H];
  bit   h_rc [H];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A result in cycle n is armed if cycle n-SL was in RUN and no reset_counter came since.
  function automatic bit armed(input int n);
    if (n < SL) return 1'b0;
    if (!h_run[(n - SL) % H]) return 1'b0;
    for (int k = n - SL; k < n; k++) if (h_rc[k % H]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all();
    chk("busy", 32'(m_state != 0), 32'(busy));
    chk("hit_valid", 32'(hit_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("hit_seed", hit_seed, q[0].s);
      chk("hit_phase", 32'(hit_phase), 32'(q[0].p));
    end
    chk("hit_count", 32'(hit_count), 32'(m_count));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("phase_err", 32'(phase_err), 32'(m_perr));
  endtask

  // Advance one cycle: apply model rules to the current inputs, clock, then compare.
  task automatic tick();
    int ph;
    bit arm, cap;
    ph = (cyc - anchor) % CS;
    next_initial = (ph == CS - 1) ^ ni_flip;
    h_seed[cyc % H]  = seed;
    h_phase[cyc % H] = ph;
    h_run[cyc % H]   = (m_state == 1);
    h_rc[cyc % H]    = reset_counter;
    arm = armed(cyc);
    cap = success && arm && (m_state != 0);
    if (q.size() > 0 && hit_ready) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEPTH) begin
        q.push_back('{h_seed[(cyc - SL) % H], h_phase[(cyc - PL) % H]});
        if (m_count < 65535) m_count++;
      end else m_ovf = 1'b1;
    end
    if (arm && (next_initial != (ph == CS - 1))) m_perr = 1'b1;
    case (m_state)
      0: if (start) begin
        m_state = 1; m_count = 0; m_ovf = 0; m_perr = 0;
      end
      1: if (stop) begin
        m_state = 2; m_left = SL;
      end
      default: begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
    endcase
    if (reset_counter) anchor = cyc + 1;
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 0; stop = 0; reset_counter = 0; success = 0; hit_ready = 0;
    ni_flip = 0;
    #1;
    chk("rst_hit_valid", 32'(hit_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_phase_err", 32'(phase_err), 32'd0);
    q.delete();
    m_state = 0; m_left = 0; m_count = 0; m_ovf = 0; m_perr = 0; cyc = 0; anchor = 0;
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic restart();
    int guard;
    guard = 0;
    success = 0;
    if (m_state == 1) begin
      stop = 1; tick(); stop = 0;
    end
    while (m_state != 0 && guard < 20) begin
      tick(); guard++;
    end
    start = 1; tick(); start = 0;
    repeat (SL) tick();
  endtask

  initial begin
    logic [31:0] exp_seeds [$];
    int n, c0;

    do_reset();
    tick();

    // First hit: success during the unarmed window is ignored, then one clean capture.
    seed = 32'h1234_5678;
    start = 1; tick(); start = 0;
    success = 1;
    repeat (SL) tick();
    chk("early_no_hit", 32'(hit_count), 32'd0);
    tick();
    success = 0;
    chk("first_seed", hit_seed, 32'h1234_5678);
    chk("first_count", 32'(hit_count), 32'd1);
    hit_ready = 1; tick();

    // reset_counter discards the next SEED_LAT results.
    reset_counter = 1; tick(); reset_counter = 0;
    success = 1;
    repeat (SL) tick();
    success = 0;
    chk("rc_no_hit", 32'(hit_count), 32'd1);
    repeat (3) tick();

    // Overflow: nine hits with the consumer stalled.
    restart();
    hit_ready = 0;
    success = 1;
    repeat (9) begin
      seed = $urandom; tick();
    end
    success = 0;
    tick();
    chk("ovf_count", 32'(hit_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    exp_seeds.delete();
    foreach (q[i]) exp_seeds.push_back(q[i].s);
    chk("ovf_depth", 32'(exp_seeds.size()), 32'd8);
    hit_ready = 1;
    for (int i = 0; i < exp_seeds.size(); i++) begin
      chk("drain_order", hit_seed, exp_seeds[i]);
      tick();
    end
    chk("drain_empty", 32'(hit_valid), 32'd0);

    // stop: capture continues through DRAIN, busy falls SEED_LAT cycles later.
    c0 = m_count;
    stop = 1; tick(); stop = 0;
    tick(); tick();
    success = 1; tick(); success = 0;
    n = 3;
    while (busy && n < 20) begin
      tick(); n++;
    end
    chk("busy_drop", 32'(n), 32'(SL));
    chk("drain_capture", 32'(hit_count), 32'(c0 + 1));
    tick();

    // Phase cross-check: correct strobes keep phase_err clear, a stray one sets it.
    restart();
    repeat (40) tick();
    chk("perr_clean", 32'(phase_err), 32'd0);
    n = 0;
    while (((cyc - anchor) % CS) != 5 && n < 20) begin
      tick(); n++;
    end
    ni_flip = 1; tick(); ni_flip = 0;
    chk("perr_set", 32'(phase_err), 32'd1);

    // Random traffic.
    restart();
    repeat (400) begin
      seed          = $urandom;
      success       = ($urandom_range(0, 2) == 0);
      hit_ready     = ($urandom_range(0, 2) != 0);
      reset_counter = ($urandom_range(0, 40) == 0);
      ni_flip       = ($urandom_range(0, 80) == 0);
      start         = ($urandom_range(0, 30) == 0);
      stop          = ($urandom_range(0, 60) == 0);
      tick();
    end
    start = 0; stop = 0; reset_counter = 0; ni_flip = 0; success = 0;

    // Asynchronous reset with three records queued.
    restart();
    hit_ready = 0;
    success = 1;
    repeat (3) begin
      seed = $urandom; tick();
    end
    success = 0;
    tick();
    chk("queued_three", 32'(hit_count), 32'd3);
    do_reset();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
